product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 114 +++++++++++
 tb/tb_product_accumulator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Product accumulator: sums a run of unsigned 16-bit products from an upstream
// 8x8 multiplier into a saturating ACC_W-bit accumulator, then holds the result
// on a valid/ready output until downstream takes it.
module product_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [ACC_W:0]   sum_full;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             xfer;

    // Saturating add of the zero-extended product; the extra bit catches overflow.
    always_comb begin
        sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_product};
        sum_ovf  = sum_full[ACC_W];
        sum_sat  = sum_ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
        xfer     = in_valid && in_ready_q;
    end

    // Run-control FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q  <= len;
                        acc_q  <= '0;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            // Empty run: go straight to presenting a zero result.
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            state_q    <= StAccum;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    if (xfer) begin
                        acc_q <= sum_sat;
                        sat_q <= sat_q | sum_ovf;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q     <= StDone;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // start is deliberately not looked at here, even on the handshake cycle.
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = acc_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (ACC_W=16 so saturation is reachable
// with short runs): stimulus pushes expected results, a monitor pops on each
// output handshake.
module tb_product_accumulator;

    localparam int unsigned ACC_W = 16;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic             busy;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic             sat;
    } res_t;

    res_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    product_accumulator #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_product(in_product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every output handshake must match the oldest expected result.
    always @(negedge clk) begin
        res_t r;
        if (!rst && out_valid && out_ready) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("out_sum", 32'(out_sum), 32'(r.sum));
                check("out_sat", 32'(out_sat), 32'(r.sat));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        cyc();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] p);
        in_valid   = 1'b1;
        in_product = p;
        cyc();
        in_valid   = 1'b0;
        in_product = 16'hDEAD;
    endtask

    task automatic expect_res(input logic [ACC_W-1:0] s, input logic sat);
        res_t r;
        r.sum = s;
        r.sat = sat;
        exp_q.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] vpat;
        int         pk;
        rst        = 1'b1;
        start      = 1'b0;
        len        = '0;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b1;
        cyc();
        cyc();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_sum", 32'(out_sum), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        rst = 1'b0;
        cyc();

        // Basic run: 100+200+300, one cycle latency after last transfer.
        expect_res(16'd600, 1'b0);
        start_run(4'd3);
        check("accum_in_ready", 32'(in_ready), 1);
        check("accum_busy", 32'(busy), 1);
        send(16'd100);
        send(16'd200);
        check("pre_last_out_valid", 32'(out_valid), 0);
        send(16'd300);
        check("lat_out_valid", 32'(out_valid), 1);
        check("done_in_ready", 32'(in_ready), 0);
        cyc();
        check("after_hs_busy", 32'(busy), 0);

        // Saturation, then the flag must clear on the next run.
        expect_res(16'hFFFF, 1'b1);
        start_run(4'd2);
        send(16'hFE01);
        send(16'h0200);
        cyc();
        expect_res(16'd5, 1'b0);
        start_run(4'd1);
        send(16'd5);
        cyc();

        // Bubbly in_valid: only valid cycles count.
        expect_res(16'd10, 1'b0);
        start_run(4'd4);
        vpat = 7'b1011001; // bit 0 first: 1,0,0,1,1,0,1
        pk = 1;
        for (int i = 0; i < 7; i++) begin
            check("bubble_out_valid", 32'(out_valid), 0);
            in_valid   = vpat[i];
            in_product = vpat[i] ? 16'(pk) : 16'hAAAA;
            if (vpat[i]) pk++;
            cyc();
        end
        in_valid = 1'b0;
        check("bubble_done", 32'(out_valid), 1);
        cyc();

        // Backpressure hold with ignored start pulses.
        out_ready = 1'b0;
        expect_res(16'd9, 1'b0);
        start_run(4'd1);
        send(16'd9);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_out_sum", 32'(out_sum), 9);
            start = (i == 2);
            len   = 4'd0;
            cyc();
        end
        start = 1'b0;
        check("hold_still_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        check("hs_start_ignored_busy", 32'(busy), 0);
        cyc();
        check("idle_busy", 32'(busy), 0);
        check("idle_out_valid", 32'(out_valid), 0);

        // Reset mid-run aborts without a result.
        start_run(4'd4);
        send(16'd1);
        send(16'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_out_sum", 32'(out_sum), 0);
        for (int i = 0; i < 3; i++) begin
            check("abort_out_valid", 32'(out_valid), 0);
            cyc();
        end
        expect_res(16'd7, 1'b0);
        start_run(4'd1);
        send(16'd7);
        check("post_abort_valid", 32'(out_valid), 1);
        cyc();

        // Empty run.
        expect_res(16'd0, 1'b0);
        check("len0_in_ready_pre", 32'(in_ready), 0);
        start_run(4'd0);
        check("len0_out_valid", 32'(out_valid), 1);
        check("len0_in_ready", 32'(in_ready), 0);
        check("len0_out_sum", 32'(out_sum), 0);
        cyc();

        // Maximum length: exactly 15 products, extra product while DONE ignored.
        expect_res(16'd15000, 1'b0);
        out_ready = 1'b0;
        start_run(4'd15);
        for (int i = 0; i < 15; i++) begin
            check("max_in_ready", 32'(in_ready), 1);
            send(16'd1000);
        end
        check("max_out_valid", 32'(out_valid), 1);
        in_valid   = 1'b1;
        in_product = 16'd50;
        cyc();
        in_valid = 1'b0;
        check("max_held_sum", 32'(out_sum), 15000);
        out_ready = 1'b1;
        cyc();
        expect_res(16'd3, 1'b0);
        start_run(4'd1);
        send(16'd3);
        cyc();
        cyc();

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
